// File: rtl/conv3x3_mac.sv
// 3x3 convolution engine: nine signed taps, bias, round/shift/clamp to an unsigned pixel.
// Four register levels (products, row sums, accumulator, output) under one global advance.
module conv3x3_mac #(
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 20,
   parameter int SHIFT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9*PIX_W-1:0]   window_data,
   input  logic                 window_valid,
   output logic                 window_ready,
   input  logic                 coef_wr,
   input  logic [3:0]           coef_addr,
   input  logic [COEF_W-1:0]    coef_data,
   output logic [PIX_W-1:0]     result_data,
   output logic                 result_valid,
   input  logic                 result_ready,
   input  logic                 clear_count,
   output logic [15:0]          result_count
);
   localparam int PROD_W = PIX_W + 1 + COEF_W;
   localparam logic signed [ACC_W-1:0] RND     = ACC_W'((1 << SHIFT) >> 1);
   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);
   localparam logic [COEF_W-1:0]       UNITY   = COEF_W'(1 << SHIFT);

   logic [9*COEF_W-1:0]       coef_q;
   logic signed [COEF_W-1:0]  bias_q;
   logic                      adv;
   logic                      s1_valid_q, s2_valid_q, s3_valid_q, result_valid_q;
   logic [9*PROD_W-1:0]       prod_d, prod_q;
   logic [3*ACC_W-1:0]        row_d, row_q;
   logic signed [ACC_W-1:0]   acc_d, acc_q, round_d;
   logic [PIX_W-1:0]          clamp_d, result_data_q;
   logic [15:0]               count_d, count_q;

   // Every stage moves together; a held output freezes the whole pipe.
   assign adv          = ~result_valid_q | result_ready;
   assign window_ready = adv;
   assign result_valid = result_valid_q;
   assign result_data  = result_data_q;
   assign result_count = count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coef_q                           <= '0;
         coef_q[4*COEF_W +: COEF_W]       <= UNITY;
         bias_q                           <= '0;
      end else if (coef_wr) begin
         for (int k = 0; k < 9; k++) begin
            if (coef_addr == 4'(k)) coef_q[k*COEF_W +: COEF_W] <= coef_data;
         end
         if (coef_addr == 4'd9) bias_q <= coef_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_prod
         assign prod_d[gi*PROD_W +: PROD_W] =
            PROD_W'($signed({1'b0, window_data[gi*PIX_W +: PIX_W]})) *
            PROD_W'($signed(coef_q[gi*COEF_W +: COEF_W]));
      end
      for (gi = 0; gi < 3; gi++) begin : g_row
         assign row_d[gi*ACC_W +: ACC_W] =
            ACC_W'($signed(prod_q[(3*gi)*PROD_W   +: PROD_W])) +
            ACC_W'($signed(prod_q[(3*gi+1)*PROD_W +: PROD_W])) +
            ACC_W'($signed(prod_q[(3*gi+2)*PROD_W +: PROD_W]));
      end
   endgenerate

   // Bias joins at the accumulator, so it is sampled late relative to the taps.
   assign acc_d   = $signed(row_q[0 +: ACC_W]) + $signed(row_q[ACC_W +: ACC_W]) +
                    $signed(row_q[2*ACC_W +: ACC_W]) + ACC_W'(bias_q);
   assign round_d = (acc_q + RND) >>> SHIFT;

   always_comb begin
      clamp_d = round_d[PIX_W-1:0];
      if (round_d[ACC_W-1])       clamp_d = '0;
      else if (round_d > PIX_MAX) clamp_d = '1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q     <= 1'b0;
         s2_valid_q     <= 1'b0;
         s3_valid_q     <= 1'b0;
         result_valid_q <= 1'b0;
         prod_q         <= '0;
         row_q          <= '0;
         acc_q          <= '0;
         result_data_q  <= '0;
      end else if (adv) begin
         s1_valid_q     <= window_valid;
         prod_q         <= prod_d;
         s2_valid_q     <= s1_valid_q;
         row_q          <= row_d;
         s3_valid_q     <= s2_valid_q;
         acc_q          <= acc_d;
         result_valid_q <= s3_valid_q;
         if (s3_valid_q) result_data_q <= clamp_d;
      end
   end

   always_comb begin
      count_d = count_q;
      if (clear_count)                        count_d = '0;
      else if (result_valid_q && result_ready) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end
endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized bench for conv3x3_mac: an arithmetic kernel model feeds a result scoreboard.
module tb_conv3x3_mac;
   localparam int SHIFT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [71:0] window_data;
   logic        window_valid;
   logic        window_ready;
   logic        coef_wr;
   logic [3:0]  coef_addr;
   logic [7:0]  coef_data;
   logic [7:0]  result_data;
   logic        result_valid;
   logic        result_ready;
   logic        clear_count;
   logic [15:0] result_count;

   conv3x3_mac #(.PIX_W(8), .COEF_W(8), .ACC_W(20), .SHIFT(SHIFT)) dut (
      .clk(clk), .reset(reset),
      .window_data(window_data), .window_valid(window_valid), .window_ready(window_ready),
      .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
      .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
      .clear_count(clear_count), .result_count(result_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int mcoef[9];
   int mbias;
   int exp_q[$];
   int last_res;
   int n_res = 0;
   bit prev_stall = 1'b0;
   logic [7:0] prev_data;
   bit stop;

   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: direct weighted sum, round half up, floor shift, clamp.
   function automatic int model_pix(input logic [71:0] w);
      int s = mbias;
      for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]) * mcoef[k];
      s = (s + ((1 << SHIFT) >> 1)) >>> SHIFT;
      if (s < 0)   s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 9; k++) mcoef[k] = 0;
      mcoef[4] = 1 << SHIFT;
      mbias    = 0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         check_eq("wready", window_ready, !result_valid || result_ready);
         if (prev_stall) begin
            check_eq("hold_valid", result_valid, 1);
            check_eq("hold_data", result_data, prev_data);
         end
         if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious", result_valid, 0);
            end else begin
               int e;
               e = exp_q.pop_front();
               check_eq("result", result_data, e);
               last_res = int'(result_data);
               n_res++;
               $display("result %0d: data=%02h exp=%02h", n_res, result_data, e[7:0]);
            end
         end
         if (window_valid && window_ready) exp_q.push_back(model_pix(window_data));
         prev_stall = result_valid && !result_ready;
         prev_data  = result_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int a, input int d);
      logic signed [7:0] d8;
      d8 = d[7:0];
      coef_wr = 1'b1; coef_addr = a[3:0]; coef_data = d8;
      tick();
      coef_wr = 1'b0;
      if (a < 9)       mcoef[a] = d8;
      else if (a == 9) mbias    = d8;
   endtask

   task automatic send_window(input logic [71:0] w);
      bit acc = 1'b0;
      window_data  = w;
      window_valid = 1'b1;
      for (int i = 0; i < 1000 && !acc; i++) begin
         @(negedge clk);
         acc = window_ready;
         tick();
      end
      window_valid = 1'b0;
      if (!acc) check_eq("accept_timeout", acc, 1);
   endtask

   task automatic drain();
      result_ready = 1'b1;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
      check_eq("drain", exp_q.size(), 0);
   endtask

   task automatic clear_cnt();
      clear_count = 1'b1;
      tick();
      clear_count = 1'b0;
   endtask

   function automatic logic [71:0] fill_win(input logic [7:0] centre, input logic [7:0] other);
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[8*k +: 8] = (k == 4) ? centre : other;
      return w;
   endfunction

   function automatic logic [71:0] rand_win();
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   task automatic set_all_taps(input int t, input int b);
      for (int k = 0; k < 9; k++) write_coef(k, t);
      write_coef(9, b);
   endtask

   task automatic rand_kernel();
      for (int k = 0; k < 9; k++) write_coef(k, int'($urandom_range(0, 32)) - 8);
      write_coef(9, int'($urandom_range(0, 64)) - 32);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [71:0] w;
      int lat;
      window_data = '0; window_valid = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
      result_ready = 1'b0; clear_count = 1'b0; reset = 1'b1;
      model_reset();
      repeat (3) tick();
      check_eq("rst_valid", result_valid, 0);
      check_eq("rst_data", result_data, 0);
      check_eq("rst_count", result_count, 0);
      check_eq("rst_wready", window_ready, 1);
      reset = 1'b0;
      result_ready = 1'b1;
      tick();

      // identity kernel and latency
      send_window(fill_win(8'h5A, 8'hFF));
      lat = 99;
      for (int k = 1; k <= 10 && lat == 99; k++) begin
         @(negedge clk);
         if (result_valid) begin
            lat = k - 1;
            check_eq("ident_data", result_data, 8'h5A);
         end
      end
      check_eq("ident_latency", lat, 3);
      tick();
      check_eq("ident_count", result_count, 1);

      // rounding threshold: 23 rounds down, 24 rounds up
      set_all_taps(1, 0);
      w = '0; w[7:0] = 8'd8; w[15:8] = 8'd8; w[23:16] = 8'd7;
      send_window(w); drain();
      check_eq("round_23", last_res, 1);
      w[23:16] = 8'd8;
      send_window(w); drain();
      check_eq("round_24", last_res, 2);

      // saturation
      set_all_taps(127, 0);
      send_window(fill_win(8'hFF, 8'hFF)); drain();
      check_eq("sat_high", last_res, 255);
      set_all_taps(-128, 0);
      send_window(fill_win(8'h10, 8'h10)); drain();
      check_eq("sat_low", last_res, 0);
      set_all_taps(0, -128);
      write_coef(4, 1 << SHIFT);
      send_window(fill_win(8'h05, 8'h00)); drain();
      check_eq("bias_neg", last_res, 0);

      // addresses above the bias are inert
      write_coef(10, 8'h55); write_coef(12, 8'h7F); write_coef(15, 8'h80);
      send_window(fill_win(8'h40, 8'h00)); drain();
      check_eq("ignored_addr", last_res, 56);

      // back-to-back stream
      rand_kernel();
      clear_cnt();
      lat = cyc;
      for (int i = 0; i < 16; i++) send_window(rand_win());
      check_eq("b2b_cycles", cyc - lat, 16);
      drain();
      check_eq("b2b_count", result_count, 16);

      // five-cycle stall mid-stream
      clear_cnt();
      fork
         for (int i = 0; i < 20; i++) send_window(rand_win());
         begin
            repeat (6) tick();
            result_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check_eq("stall_wready", window_ready, 0);
               tick();
            end
            result_ready = 1'b1;
         end
      join
      drain();
      check_eq("stall_count", result_count, 20);

      // random gaps and random backpressure
      rand_kernel();
      clear_cnt();
      stop = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) tick();
               send_window(rand_win());
            end
            stop = 1'b1;
         end
         while (!stop) begin
            tick();
            result_ready = ($urandom_range(0, 3) != 0);
         end
      join
      drain();
      check_eq("rand_count", result_count, 150);

      // reset with windows in flight
      rand_kernel();
      for (int i = 0; i < 3; i++) send_window(rand_win());
      tick();
      check_eq("pre_rst_valid", result_valid, 1);
      reset = 1'b1;
      #1;
      check_eq("rst_imm_valid", result_valid, 0);
      exp_q.delete();
      model_reset();
      repeat (2) tick();
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check_eq("post_rst_valid", result_valid, 0);
      end
      tick();
      check_eq("post_rst_count", result_count, 0);
      send_window(fill_win(8'h33, 8'hC8)); drain();
      check_eq("post_rst_ident", last_res, 8'h33);
      check_eq("post_rst_count1", result_count, 1);

      // clear coincident with a hand-off
      send_window(rand_win());
      lat = 0;
      for (int k = 0; k < 10 && lat == 0; k++) begin
         @(negedge clk);
         if (result_valid) lat = 1;
      end
      check_eq("clr_seen_valid", lat, 1);
      clear_count = 1'b1;
      tick();
      clear_count = 1'b0;
      check_eq("clr_count", result_count, 0);
      check_eq("clr_handoff", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
